instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fixed-cycle control state machine for the 8-bit RISC CPU core. It fetches each 16-bit instruction as two byte reads into the instruction register, decodes the 3-bit opcode, and drives the per-cycle control strobes for the program counter, accumulator, memory and data-bus driver. It sits between the clock-generator enable and the datapath blocks (instruction register, accumulator/ALU, PC counter, address mux, data control).

## Interface
- No parameters; every width is fixed.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  run enable from the clock generator; low holds the sequencer idle.
- opcode  in  3  instruction register bits [15:13]; valid from S2 onward.
- zero  in  1  accumulator-equals-zero flag.
- load_ir  out  1  instruction register byte-capture enable.
- inc_pc  out  1  PC increment.
- load_pc  out  1  PC load from the address field.
- load_acc  out  1  accumulator load from the ALU.
- rd  out  1  memory read strobe.
- wr  out  1  memory write strobe.
- datactl_ena  out  1  drives the accumulator onto the data bus.
- halt  out  1  processor halted.
- state  out  4  current state, for debug and verification.

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
- State encoding: S0..S7 = 0..7, HALTED = 8. Values 9..15 are illegal; on the next edge they recover to S0 with outputs 0.
- With ena=1 and not halted, the state sequence is S0→S1→…→S7→S0, so each instruction takes exactly 8 clocks. The one exception is S3 with opcode HLT, whose next state is HALTED.
- Strobes per state (any strobe not listed is 0):
  - S0 (fetch high byte): rd, load_ir, inc_pc.
  - S1 (fetch low byte): rd, load_ir, inc_pc.
  - S2 (decode): none.
  - S3: ADD/ANDD/XORR/LDA: rd. STO: datactl_ena. JMP: load_pc. SKZ: inc_pc only if zero=1. HLT: none.
  - S4: ADD/ANDD/XORR/LDA: rd and load_acc. STO: wr and datactl_ena. JMP: load_pc. SKZ: inc_pc only if zero=1. HLT: not reachable.
  - S5: STO: datactl_ena, to hold the bus one cycle past wr.
  - S6, S7: none.
- HALTED: halt=1 and every other strobe 0. The state holds regardless of ena and opcode until rst is asserted.
- ena=0: all strobes are forced to 0 combinationally. The next state is S0; if HALTED, the state stays HALTED and halt stays 1.
- SKZ with zero=1 advances the PC by 2, skipping the next 16-bit instruction.
- wr and rd are never both 1. load_pc and inc_pc are never both 1.

## Timing
- The state register is the only storage. All outputs are combinational decodes of state, opcode, zero and ena, so each strobe is valid for the whole cycle in which its state is current.
- While rst is low: state=0 and every output is 0, halt included; the fetch decode of S0 is gated by reset.
- After rst rises with ena=1, the first rising edge is the first S0 cycle: rd, load_ir and inc_pc are 1 during that cycle.
- The instruction register captures its high byte at the end of S0 and its low byte at the end of S1. opcode is stable from S2 through S7.
- zero is sampled combinationally in S3 and S4; the accumulator does not change during SKZ.
- Reset asserted mid-instruction: state goes to 0 and outputs to 0 immediately, asynchronously; no partial write completes.
- ena dropping at any state: strobes drop in the same cycle and state=S0 on the next edge. When ena returns, the sequencer restarts with a fresh fetch.

## Test plan
- Reset, ena=1, opcode=LDA: cycles 0–7 show rd/load_ir/inc_pc in S0 and S1, nothing in S2, rd in S3, rd+load_acc in S4, nothing in S5–S7; state wraps 7→0.
- opcode=STO: datactl_ena=1 in S3, S4 and S5; wr=1 only in S4; rd=0 in S3 through S7.
- opcode=SKZ with zero=1: inc_pc=1 in S3 and S4 (4 increments over the instruction). With zero=0: inc_pc=0 in S3 and S4 (2 increments).
- opcode=JMP: load_pc=1 in S3 and S4; inc_pc=0 in those states.
- opcode=HLT: state=8 from the 4th post-fetch edge, halt=1 for 20+ cycles while ena toggles and all strobes stay 0. Pulsing rst low gives state=0 and halt=0.
- opcode=ADD with ena dropped during S4: load_acc and rd fall in the same cycle and state=0 on the next edge. Raising ena gives S0 fetch strobes; pulsing rst low in S3 gives all outputs 0 with no clock edge.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer -- fixed 8-cycle fetch/decode/execute control FSM for the
// 8-bit RISC core. Each 16-bit instruction is fetched as two byte reads
// (S0, S1), decoded in S2 and executed in S3..S5. S6 and S7 are idle padding,
// so every instruction takes exactly eight clocks. HLT parks the machine in
// HALTED until reset.
//
// The state register is the only storage. Every strobe is a combinational
// decode of the current state, the opcode, the zero flag and the run enable,
// so a strobe is valid for the whole cycle in which its state is current.

module instr_sequencer (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_acc,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       halt,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        OP_HLT  = 3'b000,
        OP_SKZ  = 3'b001,
        OP_ADD  = 3'b010,
        OP_ANDD = 3'b011,
        OP_XORR = 3'b100,
        OP_LDA  = 3'b101,
        OP_STO  = 3'b110,
        OP_JMP  = 3'b111
    } opcode_e;

    state_e  state_q;
    state_e  state_d;
    opcode_e op;
    logic    run;
    logic    op_reads_mem;

    assign op           = opcode_e'(opcode);
    // Strobes only fire while out of reset and enabled; this also masks the
    // S0 fetch decode while reset holds the state at 0.
    assign run          = rst && ena;
    // Opcodes that fetch an operand from memory and load the accumulator.
    assign op_reads_mem = (op == OP_ADD) || (op == OP_ANDD) ||
                          (op == OP_XORR) || (op == OP_LDA);

    // Next-state selection: linear S0..S7 walk, HLT diverts to HALTED,
    // ena low restarts at S0, illegal encodings recover to S0.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = S0;
        unique case (state_q)
            HALTED: state_d = HALTED;
            S0:     state_d = ena ? S1 : S0;
            S1:     state_d = ena ? S2 : S0;
            S2:     state_d = ena ? S3 : S0;
            S3: begin
                if (!ena)
                    state_d = S0;
                else if (op == OP_HLT)
                    state_d = HALTED;
                else
                    state_d = S4;
            end
            S4:     state_d = ena ? S5 : S0;
            S5:     state_d = ena ? S6 : S0;
            S6:     state_d = ena ? S7 : S0;
            S7:     state_d = S0;
            default: state_d = S0;
        endcase
    end

    // State register; reset drops the machine to S0 immediately.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignment for sequential state avoids simulation races.
        if (!rst)
            state_q <= S0;
        else
            state_q <= state_d;
    end

    // Strobe decode per state; everything defaults to 0 and is only raised
    // while running. HALTED raises halt alone, independent of ena.
    always_comb begin
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;

        if (state_q == HALTED) begin
            halt = rst;
        end else if (run) begin
            unique case (state_q)
                S0, S1: begin
                    // Byte fetch: read memory, capture into IR, step the PC.
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S3: begin
                    rd          = op_reads_mem;
                    datactl_ena = (op == OP_STO);
                    load_pc     = (op == OP_JMP);
                    inc_pc      = (op == OP_SKZ) && zero;
                end
                S4: begin
                    rd          = op_reads_mem;
                    load_acc    = op_reads_mem;
                    wr          = (op == OP_STO);
                    datactl_ena = (op == OP_STO);
                    load_pc     = (op == OP_JMP);
                    inc_pc      = (op == OP_SKZ) && zero;
                end
                S5: begin
                    // Keep the accumulator on the bus one cycle past wr.
                    datactl_ena = (op == OP_STO);
                end
                default: begin
                    // S2, S6, S7 and illegal encodings drive nothing.
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. A behavioural model tracks the
// position within the current instruction and a halted flag, and derives the
// expected strobes from the per-instruction rules. Directed scenarios come
// first, then a randomized run with random ena, opcode, zero and reset pulses.

module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index within the instruction (0..7) and halted flag.
    int   m_phase  = 0;
    logic m_halted = 1'b0;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
        .load_acc(load_acc), .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
        .halt(halt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Packed observation: {halt, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena}
    function automatic logic [7:0] dut_out();
        return {halt, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena};
    endfunction

    // Expected strobes from the instruction rules.
    function automatic logic [7:0] model_out(input int ph, input logic hl,
                                             input logic [2:0] op, input logic z,
                                             input logic en, input logic r);
        logic fetch, execute, mem_op, sto, jmp, skz;
        if (!r)  return 8'h00;
        if (hl)  return 8'h80;
        if (!en) return 8'h00;
        fetch   = (ph == 0) || (ph == 1);
        execute = (ph == 3) || (ph == 4);
        mem_op  = (op >= 3'd2) && (op <= 3'd5);
        sto     = (op == 3'd6);
        jmp     = (op == 3'd7);
        skz     = (op == 3'd1);
        return {1'b0,
                fetch,
                fetch || (skz && z && execute),
                jmp && execute,
                mem_op && (ph == 4),
                fetch || (mem_op && execute),
                sto && (ph == 4),
                sto && (ph >= 3) && (ph <= 5)};
    endfunction

    function automatic logic [3:0] model_state();
        return m_halted ? 4'd8 : 4'(m_phase);
    endfunction

    // Compare all outputs against the model for the current inputs.
    task automatic compare(input string tag);
        logic [7:0] e;
        e = model_out(m_phase, m_halted, opcode, zero, ena, rst);
        check({tag, ".state"}, 16'(state), 16'(model_state()));
        check({tag, ".outs"}, 16'(dut_out()), 16'(e));
        check({tag, ".rd_wr_excl"}, 16'(rd & wr), 16'd0);
        check({tag, ".pc_excl"}, 16'(load_pc & inc_pc), 16'd0);
    endtask

    // Model update at a rising edge, from the inputs present at that edge.
    task automatic model_step();
        if (!rst) begin
            m_phase = 0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (!ena) begin
            m_phase = 0;
        end else if (m_phase == 3 && opcode == 3'd0) begin
            m_halted = 1'b1;
        end else begin
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    // One clock: apply inputs just after an edge, check at the falling edge,
    // advance the model at the next rising edge.
    task automatic cycle(input logic en, input logic [2:0] op, input logic z, input string tag);
        ena = en; opcode = op; zero = z;
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset pulse in mid-cycle: outputs must clear with no edge.
    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        m_phase = 0; m_halted = 1'b0;
        compare({tag, ".async"});
        check({tag, ".async_halt"}, 16'(halt), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int inc_count;
    int halt_cycles;

    initial begin
        // Reset held across an edge: everything at 0.
        rst = 1'b0; ena = 1'b1; opcode = 3'd5;
        @(posedge clk); #1;
        compare("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // LDA: full instruction, then wrap into the next fetch.
        for (int i = 0; i < 9; i++) cycle(1'b1, 3'd5, 1'b0, "lda");

        // Realign to S0 through ena low for one cycle.
        cycle(1'b0, 3'd5, 1'b0, "realign");

        // STO.
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'd6, 1'b0, "sto");

        // SKZ with zero=1: four PC increments over the instruction.
        inc_count = 0;
        for (int i = 0; i < 8; i++) begin
            ena = 1'b1; opcode = 3'd1; zero = 1'b1;
            @(negedge clk); compare("skz1"); inc_count += int'(inc_pc);
            @(posedge clk); model_step(); #1;
        end
        check("skz1.incs", 16'(inc_count), 16'd4);

        // SKZ with zero=0: only the two fetch increments.
        inc_count = 0;
        for (int i = 0; i < 8; i++) begin
            ena = 1'b1; opcode = 3'd1; zero = 1'b0;
            @(negedge clk); compare("skz0"); inc_count += int'(inc_pc);
            @(posedge clk); model_step(); #1;
        end
        check("skz0.incs", 16'(inc_count), 16'd2);

        // JMP.
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'd7, 1'b0, "jmp");

        // HLT: S0..S3, then HALTED for 24 cycles with ena toggling.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd0, 1'b0, "hlt_run");
        check("hlt.state8", 16'(state), 16'd8);
        for (int i = 0; i < 24; i++)
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom), "halted");
        async_reset("hlt_rst");
        check("hlt_rst.state", 16'(state), 16'd0);

        // ADD with ena dropped in S4.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd2, 1'b0, "add");
        cycle(1'b0, 3'd2, 1'b0, "add_s4_off");
        check("add_off.state0", 16'(state), 16'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd2, 1'b0, "add_restart");
        // Now in S3: async reset with no clock edge.
        check("add.in_s3", 16'(state), 16'd3);
        async_reset("add_s3");

        // Randomized run.
        halt_cycles = 0;
        for (int i = 0; i < 800; i++) begin
            logic [2:0] op;
            op = opcode;
            if (m_phase == 0 && !m_halted) begin
                op = 3'($urandom);
                if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd5;
            end
            if (m_halted) halt_cycles++;
            if ((m_halted && halt_cycles > 6) || $urandom_range(0, 99) == 0) begin
                halt_cycles = 0;
                async_reset("rnd_rst");
            end else begin
                cycle(($urandom_range(0, 9) != 0), op, 1'($urandom), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the bench must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
